t2c_maze_world_emulator: RTL

//  Synthesizable maze environment, the sensor side of the explorer interface. Holds a

---
 rtl/t2c_maze_world_emulator.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/t2c_maze_world_emulator.sv
// Maze environment for self-test of t2c_maze_explorer: loadable wall map, bot
// position/heading tracking, heading-relative wall sensors and run supervision.
module t2c_maze_world_emulator #(
  parameter int ROWS         = 9,
  parameter int COLS         = 9,
  parameter int START_POS    = 76,
  parameter int START_FACING = 0,
  parameter int EXIT_POS     = 4,
  parameter int EXIT_DIR     = 0,
  parameter int STEP_DIV     = 2,
  parameter int STEP_LIMIT   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       map_we,
  input  logic [6:0] map_addr,
  input  logic [3:0] map_wdata,
  input  logic       start,
  input  logic [2:0] move,
  output logic       left,
  output logic       mid,
  output logic       right,
  output logic [6:0] bot_pos,
  output logic [1:0] bot_facing,
  output logic       running,
  output logic       exited,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] step_count,
  output logic [6:0] dead_total,
  output logic [6:0] dead_visited,
  output logic [2:0] dbg_state
);

  localparam int         CELLS     = ROWS * COLS;
  localparam int         WIN_W     = $clog2(STEP_DIV);
  localparam logic [6:0] COLS7     = 7'(COLS);
  localparam logic [6:0] START_P7  = 7'(START_POS);
  localparam logic [6:0] START_ROW = 7'(START_POS / COLS);
  localparam logic [6:0] START_COL = 7'(START_POS % COLS);
  localparam logic [1:0] START_F2  = 2'(START_FACING);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_RUN    = 3'd2,
    S_EXITED = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  // Walls are stored {N,E,S,W}; direction d selects bit 3-d.
  function automatic logic wall_of(input logic [3:0] c, input logic [1:0] d);
    case (d)
      2'd0:    wall_of = c[3];
      2'd1:    wall_of = c[2];
      2'd2:    wall_of = c[1];
      default: wall_of = c[0];
    endcase
  endfunction

  function automatic logic is_dead(input logic [3:0] c);
    is_dead = (c == 4'b1110) || (c == 4'b1101) || (c == 4'b1011) || (c == 4'b0111);
  endfunction

  logic [3:0]       map_q [0:127];
  state_t           state_q, state_d;
  logic [6:0]       pos_q, pos_d, row_q, row_d, col_q, col_d;
  logic [1:0]       facing_q, facing_d;
  logic [2:0]       sens_q, sens_d;
  logic             exited_q, exited_d, fault_q, fault_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic [7:0]       step_q, step_d;
  logic [6:0]       dead_total_q, dead_total_d, dead_visited_q, dead_visited_d;
  logic [127:0]     visited_q, visited_d;
  logic [6:0]       scan_idx_q, scan_idx_d;
  logic [WIN_W-1:0] win_q, win_d;

  logic [3:0] cur_cell, next_cell;
  logic [1:0] new_facing;
  logic [7:0] step_inc;
  logic       at_edge, go_scan;

  // Map survives reset: written only in IDLE and only for in-range cells.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && map_we && ({1'b0, map_addr} < 8'(CELLS)))
      map_q[map_addr] <= map_wdata;
  end

  always_comb begin
    cur_cell = map_q[pos_q];
    case (move)
      3'b010:  new_facing = facing_q - 2'd1;
      3'b011:  new_facing = facing_q + 2'd1;
      3'b100:  new_facing = facing_q + 2'd2;
      default: new_facing = facing_q;
    endcase
    case (new_facing)
      2'd0:    at_edge = (row_q == 7'd0);
      2'd1:    at_edge = (col_q == COLS7 - 7'd1);
      2'd2:    at_edge = (row_q == 7'(ROWS - 1));
      default: at_edge = (col_q == 7'd0);
    endcase
    step_inc = (step_q == 8'hFF) ? 8'hFF : step_q + 8'd1;
  end

  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    row_d          = row_q;
    col_d          = col_q;
    facing_d       = facing_q;
    exited_d       = exited_q;
    fault_d        = fault_q;
    fault_code_d   = fault_code_q;
    step_d         = step_q;
    dead_total_d   = dead_total_q;
    dead_visited_d = dead_visited_q;
    visited_d      = visited_q;
    scan_idx_d     = scan_idx_q;
    win_d          = win_q;
    go_scan        = 1'b0;

    case (state_q)
      S_IDLE, S_EXITED, S_FAULT: go_scan = start;
      S_SCAN: begin
        dead_total_d = dead_total_q + {6'd0, is_dead(map_q[scan_idx_q])};
        scan_idx_d   = scan_idx_q + 7'd1;
        if (scan_idx_q == 7'(CELLS - 1)) begin
          state_d = S_RUN;
          win_d   = '0;
        end
      end
      S_RUN: begin
        win_d = (win_q == WIN_LAST) ? '0 : win_q + 1'b1;
        if (win_q == WIN_LAST) begin
          step_d = step_inc;
          if (move >= 3'b101) begin
            state_d = S_FAULT; fault_d = 1'b1; fault_code_d = 2'b11;
          end else if (move != 3'b000 && wall_of(cur_cell, new_facing)) begin
            state_d = S_FAULT; fault_d = 1'b1; fault_code_d = 2'b01;
          end else if (move != 3'b000 && at_edge) begin
            if (pos_q == 7'(EXIT_POS) && new_facing == 2'(EXIT_DIR)) begin
              state_d = S_EXITED; exited_d = 1'b1;
            end else begin
              state_d = S_FAULT; fault_d = 1'b1; fault_code_d = 2'b10;
            end
          end else if (step_inc == 8'(STEP_LIMIT)) begin
            state_d = S_FAULT; fault_d = 1'b1; fault_code_d = 2'b00;
          end else if (move != 3'b000) begin
            facing_d = new_facing;
            case (new_facing)
              2'd0:    begin pos_d = pos_q - COLS7; row_d = row_q - 7'd1; end
              2'd1:    begin pos_d = pos_q + 7'd1;  col_d = col_q + 7'd1; end
              2'd2:    begin pos_d = pos_q + COLS7; row_d = row_q + 7'd1; end
              default: begin pos_d = pos_q - 7'd1;  col_d = col_q - 7'd1; end
            endcase
            if (move == 3'b100 && is_dead(cur_cell) && !visited_q[pos_q]) begin
              visited_d[pos_q] = 1'b1;
              dead_visited_d   = dead_visited_q + 7'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new run restarts from the fixed start cell with all run state cleared.
    if (go_scan) begin
      state_d        = S_SCAN;
      scan_idx_d     = '0;
      dead_total_d   = '0;
      dead_visited_d = '0;
      visited_d      = '0;
      step_d         = '0;
      exited_d       = 1'b0;
      fault_d        = 1'b0;
      fault_code_d   = 2'b00;
      pos_d          = START_P7;
      row_d          = START_ROW;
      col_d          = START_COL;
      facing_d       = START_F2;
    end
  end

  // Sensors are registered from the next position so a new cell shows one clock after a move.
  always_comb begin
    next_cell = map_q[pos_d];
    if (state_d == S_RUN)
      sens_d = {wall_of(next_cell, facing_d - 2'd1), wall_of(next_cell, facing_d),
                wall_of(next_cell, facing_d + 2'd1)};
    else
      sens_d = 3'b111;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pos_q          <= START_P7;
      row_q          <= START_ROW;
      col_q          <= START_COL;
      facing_q       <= START_F2;
      sens_q         <= 3'b111;
      exited_q       <= 1'b0;
      fault_q        <= 1'b0;
      fault_code_q   <= 2'b00;
      step_q         <= '0;
      dead_total_q   <= '0;
      dead_visited_q <= '0;
      visited_q      <= '0;
      scan_idx_q     <= '0;
      win_q          <= '0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      row_q          <= row_d;
      col_q          <= col_d;
      facing_q       <= facing_d;
      sens_q         <= sens_d;
      exited_q       <= exited_d;
      fault_q        <= fault_d;
      fault_code_q   <= fault_code_d;
      step_q         <= step_d;
      dead_total_q   <= dead_total_d;
      dead_visited_q <= dead_visited_d;
      visited_q      <= visited_d;
      scan_idx_q     <= scan_idx_d;
      win_q          <= win_d;
    end
  end

  assign left         = sens_q[2];
  assign mid          = sens_q[1];
  assign right        = sens_q[0];
  assign bot_pos      = pos_q;
  assign bot_facing   = facing_q;
  assign running      = (state_q == S_RUN);
  assign exited       = exited_q;
  assign fault        = fault_q;
  assign fault_code   = fault_code_q;
  assign step_count   = step_q;
  assign dead_total   = dead_total_q;
  assign dead_visited = dead_visited_q;
  assign dbg_state    = state_q;

endmodule
